// File: rtl/dispatch_pkg.sv
// Shared decode constants and instruction classification for the dispatch stage.
package dispatch_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_ADD    = 7'b0000000;
  localparam logic [6:0] F7_MUL    = 7'b0000001;
  localparam logic [2:0] F3_ZERO   = 3'b000;

  typedef enum logic [1:0] {CLS_NOP, CLS_ADD, CLS_MUL, CLS_BEQ} instr_class_e;

  function automatic instr_class_e decode_class(input logic [31:0] instr);
    instr_class_e cls;
    cls = CLS_NOP;
    if (instr[6:0] == OP_RTYPE && instr[14:12] == F3_ZERO) begin
      if (instr[31:25] == F7_ADD)      cls = CLS_ADD;
      else if (instr[31:25] == F7_MUL) cls = CLS_MUL;
    end else if (instr[6:0] == OP_BRANCH && instr[14:12] == F3_ZERO) begin
      cls = CLS_BEQ;
    end
    return cls;
  endfunction

endpackage

// File: rtl/dispatch_slot_pick.sv
// Picks the lowest-index free RS slots, one per requesting lane rank, in rank order.
module dispatch_slot_pick #(
  parameter  int WIDTH    = 2,
  parameter  int RS_DEPTH = 4,
  localparam int CNTW     = $clog2(WIDTH + 1),
  localparam int SLOTW    = $clog2(RS_DEPTH)
) (
  input  logic [RS_DEPTH-1:0]          busy,
  input  logic [CNTW-1:0]              req,
  output logic [WIDTH-1:0][SLOTW-1:0]  slot,
  output logic [WIDTH-1:0]             found
);

  logic [RS_DEPTH-1:0] taken;

  always_comb begin
    taken = busy;
    slot  = '0;
    found = '0;
    for (int k = 0; k < WIDTH; k++) begin
      for (int s = 0; s < RS_DEPTH; s++) begin
        if (!found[k] && !taken[s] && k < int'(req)) begin
          found[k] = 1'b1;
          slot[k]  = SLOTW'(s);
          taken[s] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dispatch_stage.sv
// N-wide in-order dispatch: decode, RS/ROB hazard check, tag/ROB allocation, intra-group RAW.
// Optional DISPATCH_STATS_EN adds saturating dispatched-lane and stall-cycle counters.
module dispatch_stage
  import dispatch_pkg::*;
#(
  parameter  int WIDTH     = 2,
  parameter  int RS_DEPTH  = 4,
  parameter  int ROB_DEPTH = 8,
  localparam int TAGW      = 1 + $clog2(RS_DEPTH),
  localparam int ROBW      = $clog2(ROB_DEPTH),
  localparam int CNTW      = $clog2(WIDTH + 1),
  localparam int SLOTW     = $clog2(RS_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       iq_valid,
  input  logic [WIDTH*32-1:0]    iq_instr,
  output logic [CNTW-1:0]        iq_pop,
  input  logic [RS_DEPTH-1:0]    add_rs_busy,
  input  logic [RS_DEPTH-1:0]    mul_rs_busy,
  input  logic [ROBW:0]          rob_free_count,
  input  logic [ROBW-1:0]        rob_alloc_idx,
  output logic [WIDTH-1:0]       disp_valid,
  output logic [WIDTH*5-1:0]     disp_rs1,
  output logic [WIDTH*5-1:0]     disp_rs2,
  output logic [WIDTH*5-1:0]     disp_rd,
  output logic [WIDTH*TAGW-1:0]  disp_tag,
  output logic [WIDTH-1:0]       disp_src1_fwd,
  output logic [WIDTH-1:0]       disp_src2_fwd,
  output logic [WIDTH*TAGW-1:0]  disp_src1_tag,
  output logic [WIDTH*TAGW-1:0]  disp_src2_tag,
  output logic [WIDTH-1:0]       disp_is_branch,
  output logic [WIDTH*ROBW-1:0]  disp_rob_idx,
  output logic [RS_DEPTH-1:0]    add_alloc,
  output logic [RS_DEPTH-1:0]    mul_alloc
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]            stat_dispatched,
  output logic [31:0]            stat_stall_cycles
`endif
);

  typedef logic [TAGW-1:0] tag_t;
  typedef logic [ROBW-1:0] rob_idx_t;

  instr_class_e cls [WIDTH];
  logic [CNTW-1:0] add_req, mul_req;
  logic [WIDTH-1:0][SLOTW-1:0] add_slot, mul_slot;
  logic [WIDTH-1:0] add_found, mul_found;

  always_comb begin
    add_req = '0;
    mul_req = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cls[i] = decode_class(iq_instr[i*32 +: 32]);
      if (iq_valid[i] && (cls[i] == CLS_ADD || cls[i] == CLS_BEQ)) add_req = add_req + CNTW'(1);
      if (iq_valid[i] && cls[i] == CLS_MUL) mul_req = mul_req + CNTW'(1);
    end
  end

  dispatch_slot_pick #(.WIDTH(WIDTH), .RS_DEPTH(RS_DEPTH)) u_add_pick (
    .busy(add_rs_busy), .req(add_req), .slot(add_slot), .found(add_found)
  );

  dispatch_slot_pick #(.WIDTH(WIDTH), .RS_DEPTH(RS_DEPTH)) u_mul_pick (
    .busy(mul_rs_busy), .req(mul_req), .slot(mul_slot), .found(mul_found)
  );

  logic [WIDTH-1:0] nx_valid, nx_fwd1, nx_fwd2, nx_branch;
  logic [WIDTH-1:0][4:0] nx_rs1, nx_rs2, nx_rd;
  tag_t [WIDTH-1:0] nx_tag, nx_tag1, nx_tag2;
  rob_idx_t [WIDTH-1:0] nx_rob;
  logic [RS_DEPTH-1:0] nx_add_alloc, nx_mul_alloc;
  logic [CNTW-1:0] pop;
  logic [ROBW:0] n_disp;
  int n_add, n_mul;
  logic stall, ok;
  tag_t tag;
  logic [SLOTW-1:0] slot;
  logic [4:0] rs1, rs2, rd;

  // Lanes are scanned oldest first; the first lane that cannot proceed blocks all younger ones.
  always_comb begin
    nx_valid = '0; nx_fwd1 = '0; nx_fwd2 = '0; nx_branch = '0;
    nx_rs1 = '0; nx_rs2 = '0; nx_rd = '0;
    nx_tag = '0; nx_tag1 = '0; nx_tag2 = '0; nx_rob = '0;
    nx_add_alloc = '0; nx_mul_alloc = '0;
    pop = '0; n_disp = '0; n_add = 0; n_mul = 0;
    stall = 1'b0; ok = 1'b0; tag = '0; slot = '0;
    rs1 = '0; rs2 = '0; rd = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rs1 = iq_instr[i*32+15 +: 5];
      rs2 = iq_instr[i*32+20 +: 5];
      rd  = (cls[i] == CLS_BEQ) ? 5'd0 : iq_instr[i*32+7 +: 5];
      if (!rst_n || flush || !iq_valid[i] || stall) begin
        stall = 1'b1;
      end else if (cls[i] == CLS_NOP) begin
        pop = pop + CNTW'(1);
      end else begin
        ok = 1'b0;
        slot = '0;
        for (int k = 0; k < WIDTH; k++) begin
          if (cls[i] == CLS_MUL && k == n_mul) begin
            ok = mul_found[k];
            slot = mul_slot[k];
          end else if (cls[i] != CLS_MUL && k == n_add) begin
            ok = add_found[k];
            slot = add_slot[k];
          end
        end
        tag = {cls[i] == CLS_MUL, slot};
        ok = ok && (rob_free_count > n_disp);
        if (!ok) begin
          stall = 1'b1;
        end else begin
          nx_valid[i]  = 1'b1;
          nx_tag[i]    = tag;
          nx_rob[i]    = rob_alloc_idx + n_disp[ROBW-1:0];
          nx_rs1[i]    = rs1;
          nx_rs2[i]    = rs2;
          nx_rd[i]     = rd;
          nx_branch[i] = (cls[i] == CLS_BEQ);
          // Ascending scan means the youngest older producer wins.
          for (int j = 0; j < i; j++) begin
            if (nx_valid[j] && nx_rd[j] != 5'd0) begin
              if (rs1 != 5'd0 && rs1 == nx_rd[j]) begin
                nx_fwd1[i] = 1'b1;
                nx_tag1[i] = nx_tag[j];
              end
              if (rs2 != 5'd0 && rs2 == nx_rd[j]) begin
                nx_fwd2[i] = 1'b1;
                nx_tag2[i] = nx_tag[j];
              end
            end
          end
          if (cls[i] == CLS_MUL) begin
            nx_mul_alloc[slot] = 1'b1;
            n_mul = n_mul + 1;
          end else begin
            nx_add_alloc[slot] = 1'b1;
            n_add = n_add + 1;
          end
          n_disp = n_disp + (ROBW+1)'(1);
          pop = pop + CNTW'(1);
        end
      end
    end
  end

  assign iq_pop = pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_valid <= '0; disp_rs1 <= '0; disp_rs2 <= '0; disp_rd <= '0;
      disp_tag <= '0; disp_src1_fwd <= '0; disp_src2_fwd <= '0;
      disp_src1_tag <= '0; disp_src2_tag <= '0; disp_is_branch <= '0;
      disp_rob_idx <= '0; add_alloc <= '0; mul_alloc <= '0;
    end else begin
      disp_valid <= nx_valid; disp_rs1 <= nx_rs1; disp_rs2 <= nx_rs2; disp_rd <= nx_rd;
      disp_tag <= nx_tag; disp_src1_fwd <= nx_fwd1; disp_src2_fwd <= nx_fwd2;
      disp_src1_tag <= nx_tag1; disp_src2_tag <= nx_tag2; disp_is_branch <= nx_branch;
      disp_rob_idx <= nx_rob; add_alloc <= nx_add_alloc; mul_alloc <= nx_mul_alloc;
    end
  end

`ifdef DISPATCH_STATS_EN
  logic [32:0] disp_sum;
  assign disp_sum = {1'b0, stat_dispatched} + 33'($countones(nx_valid));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_dispatched   <= '0;
      stat_stall_cycles <= '0;
    end else begin
      stat_dispatched <= disp_sum[32] ? 32'hFFFF_FFFF : disp_sum[31:0];
      if (iq_valid[0] && pop == '0 && stat_stall_cycles != 32'hFFFF_FFFF)
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
